// File: rtl/aes_key_cache_if.sv
// Fill and read bundle between the AES key schedule, the cache and the round datapath.
// master: drives key_load/rk_in/rk_in_valid/rd_*; slave: returns rd_key/rd_valid/rd_err/ready/busy.
interface aes_key_cache_if #(
  parameter int KEY_S = 128
);
  logic             key_load;
  logic [KEY_S-1:0] rk_in;
  logic             rk_in_valid;
  logic             rd_en;
  logic [3:0]       rd_idx;
  logic             rd_rev;
  logic [KEY_S-1:0] rd_key;
  logic             rd_valid;
  logic             rd_err;
  logic             ready;
  logic             busy;

  modport master (
    output key_load, rk_in, rk_in_valid,
    output rd_en, rd_idx, rd_rev,
    input  rd_key, rd_valid, rd_err,
    input  ready, busy
  );

  modport slave (
    input  key_load, rk_in, rk_in_valid,
    input  rd_en, rd_idx, rd_rev,
    output rd_key, rd_valid, rd_err,
    output ready, busy
  );
endinterface

// File: rtl/aes_key_cache.sv
// Round-key cache: captures NR+1 schedule keys, serves any index with 1-cycle latency.
// Ports: clk, reset (async, active-low), bus (slave). Macro AES_KEY_CACHE_REVERSE_EN adds rd_rev.
module aes_key_cache #(
  parameter int KEY_S = 128,
  parameter int NR    = 10
) (
  input logic            clk,
  input logic            reset,
  aes_key_cache_if.slave bus
);

  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       wr_ptr_q, wr_ptr_d;
  logic             wr_en;
  logic [KEY_S-1:0] mem_q [NR+1];

  logic [3:0]       eidx;
  logic             rd_ok;
  logic             rd_bad;
  logic [KEY_S-1:0] rd_key_q, rd_key_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_err_q, rd_err_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // key_load outranks a coincident strobe.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_en    = 1'b0;
    if (bus.key_load) begin
      state_d  = FILL;
      wr_ptr_d = '0;
    end else if (state_q == FILL && bus.rk_in_valid) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + 4'd1;
      if (wr_ptr_q == LAST)
        state_d = READY;
    end
  end

  // Storage carries no reset; validity lives in the state.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= bus.rk_in;
  end

  always_comb begin
`ifdef AES_KEY_CACHE_REVERSE_EN
    eidx = bus.rd_rev ? LAST - bus.rd_idx : bus.rd_idx;
`else
    eidx = bus.rd_idx;
`endif
    // Bounds use the raw index; state is the pre-edge value.
    rd_ok      = bus.rd_en && (state_q == READY) &&
                 (bus.rd_idx <= LAST);
    rd_bad     = bus.rd_en && !rd_ok;
    rd_key_d   = rd_ok ? mem_q[eidx] : rd_key_q;
    rd_valid_d = rd_ok;
    rd_err_d   = rd_bad;
    ready_d    = (state_d == READY);
    busy_d     = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_key_q   <= rd_key_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.rd_key   = rd_key_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;

endmodule
